// File: rtl/result_display.sv
// result_display: captures the 12 convolution results (3 engines x 2x2 output
// map) on controller strobes, then cycles them onto the board display with a
// fixed dwell time per result while done is held high.
module result_display #(
  parameter int DATA_W = 8,
  parameter int DWELL  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic              pe_c00,
  input  logic              pe_c01,
  input  logic              pe_c10,
  input  logic              pe_c11,
  input  logic              sa2x2_c00,
  input  logic              sa2x2_c01,
  input  logic              sa2x2_c10,
  input  logic              sa2x2_c11,
  input  logic              sa3x3_c00,
  input  logic              sa3x3_c01,
  input  logic              sa3x3_c10,
  input  logic              sa3x3_c11,
  input  logic [DATA_W-1:0] pe_out,
  input  logic [DATA_W-1:0] sa2x2_out,
  input  logic [DATA_W-1:0] sa3x3_out,
  output logic [DATA_W-1:0] display_output,
  output logic [3:0]        display_idx,
  output logic              display_valid,
  output logic              all_captured
);

  localparam int NSLOT = 12;

  typedef enum logic {IDLE, SHOW} state_t;

  // Strobe vector ordered by slot number: slot = engine*4 + pos
  logic [NSLOT-1:0]  strb;
  logic [DATA_W-1:0] bus_sel [3];
  logic [DATA_W-1:0] slot_val [NSLOT];
  logic [NSLOT-1:0]  cap_vec;

  assign strb = {sa3x3_c11, sa3x3_c10, sa3x3_c01, sa3x3_c00,
                 sa2x2_c11, sa2x2_c10, sa2x2_c01, sa2x2_c00,
                 pe_c11,    pe_c10,    pe_c01,    pe_c00};

  assign bus_sel[0] = pe_out;
  assign bus_sel[1] = sa2x2_out;
  assign bus_sel[2] = sa3x3_out;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      logic [DATA_W-1:0] val_q;
      logic              cap_q;

      // Slot register: reload from its engine's bus whenever its strobe is high
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          val_q <= '0;
          cap_q <= 1'b0;
        end else if (strb[gi]) begin
          val_q <= bus_sel[gi/4];
          cap_q <= 1'b1;
        end
      end

      assign slot_val[gi] = val_q;
      assign cap_vec[gi]  = cap_q;
    end
  endgenerate

  assign all_captured = &cap_vec;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;

  // Display sequencer state, dwell counter and slot index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: dropping done always wins over advancing the index
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (done) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      SHOW: begin
        if (!done) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CNT_W'(DWELL - 1)) begin
          cnt_d = '0;
          idx_d = (idx_q == 4'd11) ? 4'd0 : idx_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output mux reads the live slot registers so mid-show captures appear at once
  always_comb begin
    display_valid  = (state_q == SHOW);
    display_idx    = idx_q;
    display_output = '0;
    if (state_q == SHOW) begin
      display_output = slot_val[idx_q];
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display: a time-based reference model pushes the
// expected outputs after every rising edge; a monitor pops and compares them on
// the falling edge.
module tb_result_display;

  localparam int DATA_W = 8;
  localparam int DWELL  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              done = 1'b0;
  logic [11:0]       strb = '0;
  logic [DATA_W-1:0] pe_out = '0, sa2x2_out = '0, sa3x3_out = '0;
  logic [DATA_W-1:0] display_output;
  logic [3:0]        display_idx;
  logic              display_valid;
  logic              all_captured;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       v;
    logic [3:0] idx;
    logic [7:0] out;
    logic       ac;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  result_display #(.DATA_W(DATA_W), .DWELL(DWELL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .done(done),
    .pe_c00(strb[0]), .pe_c01(strb[1]), .pe_c10(strb[2]), .pe_c11(strb[3]),
    .sa2x2_c00(strb[4]), .sa2x2_c01(strb[5]), .sa2x2_c10(strb[6]), .sa2x2_c11(strb[7]),
    .sa3x3_c00(strb[8]), .sa3x3_c01(strb[9]), .sa3x3_c10(strb[10]), .sa3x3_c11(strb[11]),
    .pe_out(pe_out), .sa2x2_out(sa2x2_out), .sa3x3_out(sa3x3_out),
    .display_output(display_output), .display_idx(display_idx),
    .display_valid(display_valid), .all_captured(all_captured)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Reference model: the shown slot is just (cycles since entering SHOW / DWELL) mod 12
  logic [7:0] m_slot [12];
  logic       m_cap  [12];
  bit         m_show;
  int         m_t;

  initial begin
    exp_t e;
    int   idx;
    bit   allc;
    for (int s = 0; s < 12; s++) begin m_slot[s] = 0; m_cap[s] = 0; end
    m_show = 0;
    m_t    = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int s = 0; s < 12; s++) begin m_slot[s] = 0; m_cap[s] = 0; end
        m_show = 0;
        m_t    = 0;
      end else begin
        for (int s = 0; s < 12; s++) begin
          if (strb[s]) begin
            m_slot[s] = (s < 4) ? pe_out : (s < 8) ? sa2x2_out : sa3x3_out;
            m_cap[s]  = 1;
          end
        end
        if (!m_show) begin
          if (done) begin m_show = 1; m_t = 0; end
        end else if (!done) begin
          m_show = 0; m_t = 0;
        end else begin
          m_t++;
        end
      end
      idx  = m_show ? (m_t / DWELL) % 12 : 0;
      allc = 1;
      for (int s = 0; s < 12; s++) if (!m_cap[s]) allc = 0;
      e.v   = m_show;
      e.idx = 4'(idx);
      e.out = m_show ? m_slot[idx] : 8'h00;
      e.ac  = allc;
      exp_q.push_back(e);
    end
  end

  // Monitor: pops one expectation per cycle; while rst is high outputs must be zero
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (rst) begin
          e.v = 0; e.idx = 0; e.out = 0; e.ac = 0;
        end
        chk("display_valid",  int'(display_valid),  int'(e.v));
        chk("display_idx",    int'(display_idx),    int'(e.idx));
        chk("display_output", int'(display_output), int'(e.out));
        chk("all_captured",   int'(all_captured),   int'(e.ac));
        $display("cyc t=%0t rst=%0b done=%0b valid=%0b idx=%0d out=%02h allc=%0b",
                 $time, rst, done, display_valid, display_idx, display_output, all_captured);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int slot, input logic [7:0] val);
    strb = '0;
    strb[slot] = 1'b1;
    if (slot < 4) pe_out = val; else if (slot < 8) sa2x2_out = val; else sa3x3_out = val;
    cyc(1);
    strb = '0;
  endtask

  initial begin
    // Reset held with random activity on every input
    rst = 1'b1;
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strb = 12'($urandom);
      pe_out = 8'($urandom); sa2x2_out = 8'($urandom); sa3x3_out = 8'($urandom);
      #3;
      chk("async_reset_out",   int'(display_output), 0);
      chk("async_reset_valid", int'(display_valid), 0);
      cyc(1);
    end
    @(posedge clk); #1;
    rst = 1'b0; done = 1'b0; strb = '0;
    cyc(4);

    // Capture map: three single-slot pulses, then a full show
    pulse(1, 8'h11);
    pulse(6, 8'h22);
    pulse(11, 8'h33);
    cyc(1);
    done = 1'b1;
    cyc(52);
    done = 1'b0;
    cyc(2);

    // All strobes together
    pe_out = 8'hA1; sa2x2_out = 8'hB2; sa3x3_out = 8'hC3;
    strb = 12'hFFF;
    cyc(1);
    strb = '0;
    cyc(1);

    // Sequencing over 60 cycles with an overwrite while slot 2 is shown
    done = 1'b1;
    cyc(9);
    pulse(2, 8'h7F);
    cyc(50);
    done = 1'b0;
    cyc(2);

    // Abort while slot 5 is shown, then restart
    done = 1'b1;
    cyc(21);
    done = 1'b0;
    cyc(3);
    done = 1'b1;
    cyc(14);

    // Randomized capture / done activity
    for (int i = 0; i < 400; i++) begin
      strb = ($urandom_range(0, 5) == 0) ? 12'($urandom) : 12'h000;
      pe_out = 8'($urandom); sa2x2_out = 8'($urandom); sa3x3_out = 8'($urandom);
      if ($urandom_range(0, 39) == 0) done = ~done;
      cyc(1);
    end
    strb = '0;

    // Reset asserted between edges in the middle of a show
    done = 1'b1;
    cyc(17);
    #3;
    rst = 1'b1;
    #1;
    chk("midshow_rst_valid", int'(display_valid), 0);
    chk("midshow_rst_out",   int'(display_output), 0);
    chk("midshow_rst_idx",   int'(display_idx), 0);
    chk("midshow_rst_allc",  int'(all_captured), 0);
    cyc(3);
    rst = 1'b0;
    cyc(10);
    done = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
